// File: rtl/bridge_ram_pkg.sv
// bridge_ram_pkg: FSM state encoding and parameter sanity checks for bridge_ram_arbiter
package bridge_ram_pkg;
  typedef enum logic [1:0] {IDLE, UNL_RD, CORE_RD} state_t;
  function automatic bit deadline_ok(int mem_latency, int unl_deadline);
    return unl_deadline >= 2 * mem_latency + 2;
  endfunction
endpackage

// File: rtl/bridge_edge_latch.sv
// bridge_edge_latch: rising-edge detect on unl_read_en with pending flag and address hold
module bridge_edge_latch #(
  parameter int ADDRESS_SIZE = 17
) (
  input  logic                    clk_memory,
  input  logic                    reset_n,
  input  logic                    unl_read_en,
  input  logic [ADDRESS_SIZE-1:0] unl_read_addr,
  input  logic                    take,
  output logic                    unl_req,
  output logic [ADDRESS_SIZE-1:0] unl_addr
);
  logic en_q, pending, rise;
  logic [ADDRESS_SIZE-1:0] addr_q;
  assign rise = unl_read_en && !en_q;
  assign unl_req = rise || pending;
  assign unl_addr = rise ? unl_read_addr : addr_q;
  always_ff @(posedge clk_memory or negedge reset_n)
    if (!reset_n) begin
      en_q <= 1'b0;
      pending <= 1'b0;
      addr_q <= '0;
    end else begin
      en_q <= unl_read_en;
      pending <= unl_req && !take;
      if (rise) addr_q <= unl_read_addr;
    end
endmodule

// File: rtl/bridge_ram_arbiter.sv
// bridge_ram_arbiter: shares one 16-bit RAM between the bridge unloader (priority) and the core
module bridge_ram_arbiter import bridge_ram_pkg::*; #(
  parameter int ADDRESS_SIZE  = 17,
  parameter int UNL_WORD_SIZE = 1,
  parameter int MEM_LATENCY   = 1,
  parameter int UNL_DEADLINE  = 4
) (
  input  logic                         clk_memory,
  input  logic                         reset_n,
  input  logic                         unl_read_en,
  input  logic [ADDRESS_SIZE-1:0]      unl_read_addr,
  output logic [8*UNL_WORD_SIZE-1:0]   unl_read_data,
  input  logic                         core_req,
  input  logic                         core_we,
  input  logic [ADDRESS_SIZE-1:0]      core_addr,
  input  logic [15:0]                  core_wdata,
  input  logic [1:0]                   core_be,
  output logic                         core_ready,
  output logic [15:0]                  core_rdata,
  output logic                         core_rvalid,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDRESS_SIZE-2:0]      mem_addr,
  output logic [15:0]                  mem_wdata,
  output logic [1:0]                   mem_be,
  input  logic [15:0]                  mem_rdata
);
  localparam int W = 8 * UNL_WORD_SIZE;
  if (!deadline_ok(MEM_LATENCY, UNL_DEADLINE) || MEM_LATENCY < 1 || MEM_LATENCY > 4 ||
      (UNL_WORD_SIZE != 1 && UNL_WORD_SIZE != 2)) begin : g_bad_params
    $error("bridge_ram_arbiter: unsupported MEM_LATENCY/UNL_WORD_SIZE/UNL_DEADLINE");
  end
  state_t state;
  logic [2:0] cnt;
  logic unl_req, unl_lsb, done, free, take, core_go, unused;
  logic [ADDRESS_SIZE-1:0] unl_addr;
  logic [7:0] unl_byte;
  bridge_edge_latch #(.ADDRESS_SIZE(ADDRESS_SIZE)) u_edge (
    .clk_memory    (clk_memory),
    .reset_n       (reset_n),
    .unl_read_en   (unl_read_en),
    .unl_read_addr (unl_read_addr),
    .take          (take),
    .unl_req       (unl_req),
    .unl_addr      (unl_addr)
  );
  // the final wait cycle of a read also dispatches the next access, keeping worst-case latency at 2*L+2
  assign done = state != IDLE && cnt == 3'(MEM_LATENCY);
  assign free = state == IDLE || done;
  assign take = free && unl_req;
  assign core_go = free && !unl_req && core_req && !core_ready;
  assign unl_byte = unl_lsb ? mem_rdata[15:8] : mem_rdata[7:0];
  assign unused = core_addr[0];
  always_ff @(posedge clk_memory or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      unl_lsb <= 1'b0;
      unl_read_data <= '0;
      core_ready <= 1'b0;
      core_rdata <= '0;
      core_rvalid <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
    end else begin
      mem_en <= take || core_go;
      mem_we <= core_go && core_we;
      mem_addr <= take ? unl_addr[ADDRESS_SIZE-1:1] : core_go ? core_addr[ADDRESS_SIZE-1:1] : '0;
      mem_wdata <= core_go ? core_wdata : '0;
      mem_be <= core_go ? core_be : '0;
      core_ready <= core_go;
      core_rvalid <= done && state == CORE_RD;
      if (done && state == CORE_RD) core_rdata <= mem_rdata;
      if (done && state == UNL_RD) unl_read_data <= W'(UNL_WORD_SIZE == 2 ? mem_rdata : {8'h00, unl_byte});
      if (take) unl_lsb <= unl_addr[0];
      cnt <= free ? 3'd0 : cnt + 3'd1;
      state <= take ? UNL_RD : (core_go && !core_we) ? CORE_RD : free ? IDLE : state;
    end
endmodule

// File: doc/bridge_ram_arbiter.md
Name: bridge_ram_arbiter

Overview:
- Memory-clock-domain stage directly downstream of the APF bridge read unloader.
- Services the unloader's fixed-latency read port (unl_read_en, unl_read_addr, unl_read_data) and the core's own request/ready RAM port.
- Both ports share a single 16-bit synchronous single-port RAM (save/cart RAM).
- Unloader reads have priority so that they always meet the unloader's fixed read deadline; core accesses stall via core_ready.

Parameters:
- ADDRESS_SIZE, 17: byte-address width of unl_read_addr and core_addr.
- UNL_WORD_SIZE, 1: unloader word size in bytes; 1 or 2.
- MEM_LATENCY, 1: RAM cycles from mem_en to valid mem_rdata; range 1..4.
- UNL_DEADLINE, 4: unloader's READ_MEM_CLOCK_DELAY. Must satisfy ≥ 2*MEM_LATENCY+2; elaboration-time check.

Ports:
- clk_memory  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- unl_read_en  in  1  unloader read strobe; held high ≥1 cycle per read
- unl_read_addr  in  ADDRESS_SIZE  unloader byte address
- unl_read_data  out  8*UNL_WORD_SIZE  registered read data to unloader
- core_req  in  1  core access request; held until accepted
- core_we  in  1  1=write, 0=read
- core_addr  in  ADDRESS_SIZE  core byte address; bit 0 ignored
- core_wdata  in  16  write data
- core_be  in  2  byte enables
- core_ready  out  1  request accepted this cycle
- core_rdata  out  16  read data
- core_rvalid  out  1  one-cycle pulse, core_rdata valid
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write
- mem_addr  out  ADDRESS_SIZE-1  RAM word address
- mem_wdata  out  16  RAM write data
- mem_be  out  2  RAM byte enables
- mem_rdata  in  16  RAM read data, MEM_LATENCY after mem_en

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; unl_pending=0; latency counter=0.
- Unloader trigger: rising edge of unl_read_en (registered previous value). Address captured on the edge cycle. A level held high never triggers twice.
- FSM states: IDLE, UNL_RD, CORE_RD.
- IDLE:
  - If unl_pending or unloader edge: drive mem_en=1, mem_we=0, mem_addr=addr[ADDRESS_SIZE-1:1]; go to UNL_RD.
  - Else if core_req: drive core_ready=1, mem_en=1, mem_we=core_we, mem_addr, mem_wdata, mem_be.
    - Write: stays IDLE; completes in 1 cycle.
    - Read: go to CORE_RD.
- UNL_RD: count MEM_LATENCY cycles, then:
  - UNL_WORD_SIZE=1: capture the mem_rdata byte selected by addr[0] (0 → [7:0], 1 → [15:8]) into unl_read_data.
  - UNL_WORD_SIZE=2: capture the full word into unl_read_data.
  - Return to IDLE.
- CORE_RD: after MEM_LATENCY cycles, core_rdata=mem_rdata, core_rvalid=1 for 1 cycle; return to IDLE.
- An unloader edge arriving in CORE_RD or UNL_RD sets unl_pending and captures the address; serviced on the next IDLE cycle.
- Simultaneous unloader edge and core_req in IDLE: unloader wins; core_ready=0 that cycle.
- Worst-case unloader latency (edge to unl_read_data valid) is 2*MEM_LATENCY+2, which is ≤ UNL_DEADLINE by parameter constraint.
- unl_read_data holds its value until the next unloader capture.
- mem_en, core_ready, core_rvalid are single-cycle pulses. mem_* are 0 when idle.
- Reset mid-operation: in-flight results are discarded; no core_rvalid or unl_read_data update after reset.

Decomposition:
- Package bridge_ram_pkg holds the FSM state enum (IDLE, UNL_RD, CORE_RD) and the unloader deadline check function.
- Sub-module: bridge_edge_latch, which does rising-edge detect on unl_read_en plus the pending flag and address hold.
- Latency counter and FSM stay inline.

Test Plan:
- Idle unloader read: RAM word 0x0010 = 0xBEEF, UNL_WORD_SIZE=1, MEM_LATENCY=1.
  - Edge at addr 0x21 → mem_en with mem_addr 0x10 next edge; unl_read_data=0xBE within 3 cycles.
  - addr 0x20 → 0xEF.
- Core write then read: write 0x1234 to addr 0x40 with be=2'b01, over prior 0xFFFF.
  - core_ready pulse; read back gives core_rdata=0xFF34 with core_rvalid after MEM_LATENCY+1 cycles.
- Collision: core_req read and unloader edge in the same cycle.
  - Unloader serviced first; core_ready delayed exactly MEM_LATENCY+1 cycles; both return correct data.
- Unloader during core read: edge arrives in CORE_RD with MEM_LATENCY=2.
  - unl_read_data valid ≤ 6 cycles after edge; core_rvalid correct.
- Held level: unl_read_en high for 5 cycles → exactly one mem_en; four back-to-back edges at addr 0..3 return 4 correct bytes.
- Reset: assert reset_n=0 during UNL_RD → all outputs 0 immediately; after release, no stale unl_read_data update or core_rvalid.
